router_port_tx: RTL

- Packet transmitter that drives one serial input port of the 4-port Router (frame/valid/data plus grant).
- Accepts a byte stream with a destination address from an upstream parallel source, then serializes it:
  - address header first,
  - then waits for the router's grant,
  - then sends payload bits LSB first.
- One instance per router input port; forms the sending end of the Router ingress protocol.

---
 rtl/router_port_tx_if.sv | 27 ++
 rtl/router_port_tx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/router_port_tx_if.sv
// Upstream byte stream and router serial-port signals of one router_port_tx.
// master: upstream source / router side; slave: the transmitter.
interface router_port_tx_if #(
    parameter int ADDR_W = 4
) ();
    logic              s_valid;
    logic              s_ready;
    logic [7:0]        s_data;
    logic              s_last;
    logic [ADDR_W-1:0] s_dst;
    logic              o_frame;
    logic              o_valid;
    logic              o_data;
    logic              i_grant;
    logic              o_busy;
    logic              o_timeout;

    modport master (
        output s_valid, s_data, s_last, s_dst, i_grant,
        input  s_ready, o_frame, o_valid, o_data, o_busy, o_timeout
    );

    modport slave (
        input  s_valid, s_data, s_last, s_dst, i_grant,
        output s_ready, o_frame, o_valid, o_data, o_busy, o_timeout
    );
endinterface

// File: rtl/router_port_tx.sv
// Router ingress transmitter: address header, pad/wait-for-grant, LSB-first payload.
// Optional grant timeout with packet drop: define ROUTER_TX_GNT_TIMEOUT_EN.
module router_port_tx #(
    parameter int ADDR_W      = 4,
    parameter int PAD_MIN     = 1,
    parameter int GNT_TIMEOUT = 64
) (
    input logic              clk,
    input logic              reset_n,
    router_port_tx_if.slave  bus
);
    localparam int AW = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;
    localparam int PW = (GNT_TIMEOUT > 0) ? $clog2(GNT_TIMEOUT + 1) : 1;
    localparam logic [AW-1:0] ADDR_LAST = AW'(ADDR_W - 1);
    // pad_cnt holds PAD cycles already spent, so grant counts from the PAD_MIN-th cycle on
    localparam logic [PW-1:0] PAD_THR = PW'((PAD_MIN > 0) ? PAD_MIN - 1 : 0);
    localparam logic [PW-1:0] PAD_SAT = {PW{1'b1}};
`ifdef ROUTER_TX_GNT_TIMEOUT_EN
    localparam logic [PW-1:0] TMO_THR = PW'(GNT_TIMEOUT - 1);
`endif

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        PAD,
        DATA,
        GAP
`ifdef ROUTER_TX_GNT_TIMEOUT_EN
        , DROP
`endif
    } state_t;

    state_t            state;
    logic [7:0]        byte_q;
    logic              last_q;
    logic [ADDR_W-1:0] dst_q;
    logic [AW-1:0]     addr_cnt;
    logic [2:0]        bit_cnt;
    logic [PW-1:0]     pad_cnt;
    logic              frame_q;
    logic              valid_q;
    logic              data_q;
    logic              busy_q;
`ifdef ROUTER_TX_GNT_TIMEOUT_EN
    logic              tmo_q;
`endif

    logic          ready;
    logic          xfer;
    logic          grant_ok;
    logic [AW-1:0] addr_nxt;
    logic [2:0]    bit_nxt;

    always_comb begin
        ready = 1'b0;
        case (state)
            IDLE, GAP: ready = 1'b1;
            DATA:      ready = (bit_cnt == 3'd7) && !last_q;
`ifdef ROUTER_TX_GNT_TIMEOUT_EN
            DROP:      ready = 1'b1;
`endif
            default:   ready = 1'b0;
        endcase
    end

    assign xfer     = bus.s_valid && ready;
    assign grant_ok = (pad_cnt >= PAD_THR) && bus.i_grant;
    assign addr_nxt = addr_cnt + 1'b1;
    assign bit_nxt  = bit_cnt + 3'd1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            byte_q   <= '0;
            last_q   <= 1'b0;
            dst_q    <= '0;
            addr_cnt <= '0;
            bit_cnt  <= '0;
            pad_cnt  <= '0;
            frame_q  <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef ROUTER_TX_GNT_TIMEOUT_EN
            tmo_q    <= 1'b0;
`endif
        end else begin
`ifdef ROUTER_TX_GNT_TIMEOUT_EN
            tmo_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (xfer) begin
                        byte_q   <= bus.s_data;
                        last_q   <= bus.s_last;
                        dst_q    <= bus.s_dst;
                        addr_cnt <= '0;
                        state    <= ADDR;
                        frame_q  <= 1'b1;
                        valid_q  <= 1'b0;
                        data_q   <= bus.s_dst[0];
                        busy_q   <= 1'b1;
                    end
                end
                ADDR: begin
                    if (addr_cnt == ADDR_LAST) begin
                        state   <= PAD;
                        pad_cnt <= '0;
                        data_q  <= 1'b0;
                    end else begin
                        addr_cnt <= addr_nxt;
                        data_q   <= dst_q[addr_nxt];
                    end
                end
                PAD: begin
                    if (grant_ok) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        valid_q <= 1'b1;
                        data_q  <= byte_q[0];
`ifdef ROUTER_TX_GNT_TIMEOUT_EN
                    end else if (pad_cnt == TMO_THR) begin
                        // a single-byte packet has nothing left to drain upstream
                        tmo_q   <= 1'b1;
                        frame_q <= 1'b0;
                        state   <= last_q ? IDLE : DROP;
                        busy_q  <= !last_q;
`endif
                    end else if (pad_cnt != PAD_SAT) begin
                        pad_cnt <= pad_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_cnt == 3'd7) begin
                        bit_cnt <= '0;
                        if (last_q) begin
                            state   <= IDLE;
                            valid_q <= 1'b0;
                            data_q  <= 1'b0;
                            busy_q  <= 1'b0;
                        end else if (xfer) begin
                            byte_q  <= bus.s_data;
                            last_q  <= bus.s_last;
                            data_q  <= bus.s_data[0];
                        end else begin
                            state   <= GAP;
                            valid_q <= 1'b0;
                            data_q  <= 1'b0;
                        end
                    end else begin
                        // frame falls together with the final bit of the last byte
                        bit_cnt <= bit_nxt;
                        data_q  <= byte_q[bit_nxt];
                        frame_q <= !(last_q && (bit_nxt == 3'd7));
                    end
                end
                GAP: begin
                    if (xfer) begin
                        byte_q  <= bus.s_data;
                        last_q  <= bus.s_last;
                        bit_cnt <= '0;
                        state   <= DATA;
                        valid_q <= 1'b1;
                        data_q  <= bus.s_data[0];
                    end
                end
`ifdef ROUTER_TX_GNT_TIMEOUT_EN
                DROP: begin
                    if (xfer && bus.s_last) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.s_ready = ready;
    assign bus.o_frame = frame_q;
    assign bus.o_valid = valid_q;
    assign bus.o_data  = data_q;
    assign bus.o_busy  = busy_q;
`ifdef ROUTER_TX_GNT_TIMEOUT_EN
    assign bus.o_timeout = tmo_q;
`else
    assign bus.o_timeout = 1'b0;
`endif
endmodule
